// File: rtl/handshake_elastic_fifo_pkg.sv
// Shared definitions for the handshake elastic FIFO: pointer sizing helper and
// the legal range of the NUM_SLOTS parameter.
package handshake_pkg;

  // Smallest and largest supported storage depth (inclusive).
  localparam int MIN_SLOTS = 2;
  localparam int MAX_SLOTS = 256;

  // Bits needed to index n distinct values (never less than 1).
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // True when n is a supported storage depth.
  function automatic bit slots_legal(input int n);
    return (n >= MIN_SLOTS) && (n <= MAX_SLOTS);
  endfunction

endpackage

// File: rtl/handshake_elastic_fifo_storage.sv
// Register-file storage for the elastic FIFO: one synchronous write port and
// one asynchronous read port. Contents are deliberately left unreset.
module handshake_fifo_storage
  import handshake_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLOTS  = 4,
  parameter int PTR_W      = ptr_width(NUM_SLOTS)
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [PTR_W-1:0]      wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [PTR_W-1:0]      rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_SLOTS];

  // Write the incoming token into the addressed slot.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Head-of-queue read is combinational so the token is visible the cycle after its write.
  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/handshake_elastic_fifo.sv
// Elastic valid/ready FIFO with a circular buffer of NUM_SLOTS entries
// (any depth in 2..256, not restricted to powers of two).
// Optional feature: define HANDSHAKE_FIFO_BYPASS_EN to let a token pass straight
// from ins to outs in the same cycle when the FIFO is empty.
// ins_ready depends only on registered occupancy and rst, never on outs_ready,
// so a full FIFO cannot accept a token in the same cycle that it drains one.
module handshake_elastic_fifo
  import handshake_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLOTS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  localparam int PTR_W = ptr_width(NUM_SLOTS);
  localparam int CNT_W = ptr_width(NUM_SLOTS + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_SLOTS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_SLOTS);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty, full, push, wr_en, rd_en;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign ins_ready = !full && !rst;
  assign push      = ins_valid && ins_ready;

`ifdef HANDSHAKE_FIFO_BYPASS_EN
  // Empty FIFO: present the upstream token directly; only store it if downstream stalls.
  assign outs_valid = empty ? (ins_valid && !rst) : 1'b1;
  assign outs       = empty ? ins : rd_data;
  assign wr_en      = push && !(empty && outs_ready);
`else
  assign outs_valid = !empty;
  assign outs       = rd_data;
  assign wr_en      = push;
`endif

  // A stored token leaves only when downstream accepts it outside reset.
  assign rd_en = !empty && outs_ready && !rst;

  handshake_fifo_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_SLOTS  (NUM_SLOTS),
    .PTR_W      (PTR_W)
  ) u_storage (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (ins),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  // Advance pointers with explicit wrap at NUM_SLOTS-1 and track occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (rd_en) begin
      rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset drops every buffered token.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_handshake_elastic_fifo.sv
// Self-checking bench: two FIFO instances (4 and 3 slots) share one stimulus
// stream; each is compared every cycle against a queue-based model.
module tb_handshake_elastic_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ins = 32'h0;
  logic        ins_valid = 1'b0;
  logic        outs_ready = 1'b0;

  logic [31:0] outs4, outs3;
  logic        ov4, ov3, ir4, ir3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  handshake_elastic_fifo #(.DATA_WIDTH(32), .NUM_SLOTS(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .ins        (ins),
    .ins_valid  (ins_valid),
    .ins_ready  (ir4),
    .outs       (outs4),
    .outs_valid (ov4),
    .outs_ready (outs_ready)
  );

  handshake_elastic_fifo #(.DATA_WIDTH(32), .NUM_SLOTS(3)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .ins        (ins),
    .ins_valid  (ins_valid),
    .ins_ready  (ir3),
    .outs       (outs3),
    .outs_valid (ov3),
    .outs_ready (outs_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of held tokens per instance.
  logic [31:0] mq [2][$];
  int          cap [2] = '{4, 3};
  int          pushed [2] = '{0, 0};
  logic        stalled_prev [2] = '{1'b0, 1'b0};
  logic [31:0] prev_o [2];

  initial begin
    forever begin
      @(negedge clk);
      #2;
      for (int k = 0; k < 2; k++) begin
        logic [31:0] ao, exp_o;
        logic        aov, air, exp_ov, exp_ir, byp, push, pop;
        ao  = (k == 0) ? outs4 : outs3;
        aov = (k == 0) ? ov4 : ov3;
        air = (k == 0) ? ir4 : ir3;
        exp_ir = (mq[k].size() != cap[k]) && !rst;
        exp_ov = (mq[k].size() != 0);
        exp_o  = exp_ov ? mq[k][0] : 32'h0;
        byp    = 1'b0;
`ifdef HANDSHAKE_FIFO_BYPASS_EN
        if (mq[k].size() == 0) begin
          byp    = 1'b1;
          exp_ov = ins_valid && !rst;
          exp_o  = ins;
        end
`endif
        chk((k == 0) ? "ins_ready[4]" : "ins_ready[3]", {31'b0, air}, {31'b0, exp_ir});
        chk((k == 0) ? "outs_valid[4]" : "outs_valid[3]", {31'b0, aov}, {31'b0, exp_ov});
        if (exp_ov) chk((k == 0) ? "outs[4]" : "outs[3]", ao, exp_o);
        if (stalled_prev[k] && aov) chk((k == 0) ? "hold[4]" : "hold[3]", ao, prev_o[k]);
        push = ins_valid && exp_ir;
        pop  = exp_ov && outs_ready && !rst;
        if (rst) begin
          mq[k].delete();
        end else if (byp) begin
          if (push && !outs_ready) mq[k].push_back(ins);
        end else begin
          if (pop) void'(mq[k].pop_front());
          if (push) mq[k].push_back(ins);
        end
        if (push) pushed[k]++;
        stalled_prev[k] = exp_ov && !outs_ready && !rst;
        prev_o[k] = ao;
      end
    end
  end

  // Drive one cycle of inputs at the falling edge; returns after the model check.
  task automatic step(input logic r, input logic v, input logic [31:0] d, input logic rdy);
    @(negedge clk);
    rst = r; ins_valid = v; ins = d; outs_ready = rdy;
    #3;
  endtask

  initial begin
    logic [31:0] pat [4];
    int base, cyc;
    pat[0] = 32'h1C; pat[1] = 32'h2A; pat[2] = 32'h3F; pat[3] = 32'h44;

    // Reset, then first idle cycle.
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("rst_ins_ready", {31'b0, ir4}, 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
`ifdef HANDSHAKE_FIFO_BYPASS_EN
    step(1'b0, 1'b1, 32'h1C, 1'b1);
    chk("bypass_outs", outs4, 32'h1C);
    chk("bypass_valid", {31'b0, ov4}, 32'd1);
`else
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("idle_outs_valid", {31'b0, ov4}, 32'd0);
`endif
    chk("idle_ins_ready", {31'b0, ir4}, 32'd1);

    // Fill the 4-slot FIFO with downstream stalled.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, pat[i], 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("full_ins_ready", {31'b0, ir4}, 32'd0);
    chk("full_head", outs4, 32'h1C);

    // Full with both sides active: pop only, then drain in order.
    step(1'b0, 1'b1, 32'h99, 1'b1);
    chk("full_pop_no_push", {31'b0, ir4}, 32'd0);
    chk("drain0", outs4, 32'h1C);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("ready_after_pop", {31'b0, ir4}, 32'd1);
    chk("drain1", outs4, 32'h2A);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("drain2", outs4, 32'h3F);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("drain3", outs4, 32'h44);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("drained_valid", {31'b0, ov4}, 32'd0);

    // Continuous stream through the 3-slot FIFO: pointers wrap, no bubbles.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 32'(i), 1'b1);
      if (i >= 1) begin
        chk("stream_valid", {31'b0, ov3}, 32'd1);
`ifdef HANDSHAKE_FIFO_BYPASS_EN
        chk("stream_data", outs3, 32'(i));
`else
        chk("stream_data", outs3, 32'(i - 1));
`endif
      end
    end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("stream_empty", {31'b0, ov3}, 32'd0);

    // Reset with two tokens held, then one fresh token.
    step(1'b0, 1'b1, 32'hA1, 1'b0);
    step(1'b0, 1'b1, 32'hA2, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("midrst_ins_ready", {31'b0, ir4}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("postrst_valid", {31'b0, ov4}, 32'd0);
    chk("postrst_ready", {31'b0, ir4}, 32'd1);
    step(1'b0, 1'b1, 32'h55, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("postrst_data", outs4, 32'h55);
    chk("postrst_data_valid", {31'b0, ov4}, 32'd1);
    step(1'b0, 1'b0, 32'h0, 1'b1);

    // Random traffic: 1000 tokens through the 4-slot instance.
    base = pushed[0];
    cyc  = 0;
    while ((pushed[0] - base) < 1000 && cyc < 8000) begin
      step(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      cyc++;
    end
    chk("random_tokens", 32'((pushed[0] - base) >= 1000), 32'd1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("final_empty4", {31'b0, ov4}, 32'd0);
    chk("final_empty3", {31'b0, ov3}, 32'd0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/handshake_elastic_fifo.md
HANDSHAKE_ELASTIC_FIFO -- requirements
Module: handshake_elastic_fifo

Interface
REQ-001 Parameter DATA_WIDTH SHALL default to 32 and set the width of the ins and outs data buses.
REQ-002 Parameter NUM_SLOTS SHALL default to 4 and set storage depth; legal range is 2..256, and non-powers of two are legal.
REQ-003 Port clk  input  1  sole clock; every register SHALL update on the rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-005 Port ins  input  DATA_WIDTH  upstream data, e.g. the output of a constant stage.
REQ-006 Port ins_valid  input  1  upstream valid.
REQ-007 Port ins_ready  output  1  ready returned to upstream.
REQ-008 Port outs  output  DATA_WIDTH  downstream data.
REQ-009 Port outs_valid  output  1  downstream valid.
REQ-010 Port outs_ready  input  1  downstream ready.

Function
REQ-011 A push SHALL occur in any cycle with ins_valid && ins_ready, and a pop in any cycle with outs_valid && outs_ready.
REQ-012 Storage SHALL be a circular buffer with wr_ptr, rd_ptr and count in 0..NUM_SLOTS; order SHALL be strictly FIFO, with no loss and no duplication.
REQ-013 Each pointer SHALL increment on its event and wrap from NUM_SLOTS-1 to 0; there SHALL be no power-of-two assumption.
REQ-014 Count SHALL update as follows: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-015 ins_ready SHALL equal (count != NUM_SLOTS) && !rst, derived from registers only, with no combinational path from outs_ready.
REQ-016 When full, a simultaneous pop SHALL NOT enable a push in the same cycle; ins_ready stays low until the cycle after the pop.
REQ-017 outs_valid SHALL equal (count != 0), and outs SHALL equal the entry at rd_ptr.
REQ-018 Default latency SHALL be 1 cycle: a token pushed in cycle N is first visible on outs in cycle N+1.
REQ-019 Simultaneous push and pop SHALL be legal at any occupancy 1..NUM_SLOTS-1, and at 0 only under REQ-028.
REQ-020 While outs_valid is high and outs_ready is low, outs SHALL hold stable.
REQ-021 Throughput SHALL be one token per cycle in steady state when downstream is always ready.
REQ-022 outs SHALL be don't-care while outs_valid is low.

Reset
REQ-023 When rst is high at a clock edge, wr_ptr, rd_ptr and count SHALL clear to 0.
REQ-024 In the cycle after reset, outs_valid SHALL be 0 and ins_ready SHALL be 1; ins_ready SHALL be 0 in any cycle where rst is high.
REQ-025 Storage contents SHALL NOT be reset.
REQ-026 Reset asserted mid-operation SHALL discard all buffered tokens, and no push or pop SHALL occur in a reset cycle.

Configuration
REQ-027 Macro HANDSHAKE_FIFO_BYPASS_EN SHALL select bypass behaviour; without it, REQ-017 and REQ-018 apply unchanged.
REQ-028 With the macro defined and count == 0, outs SHALL equal ins and outs_valid SHALL equal ins_valid combinationally, giving 0-cycle latency.
REQ-029 In that bypass case, if outs_ready is high, the token SHALL NOT be stored and count SHALL stay 0; otherwise it SHALL be stored as a normal push.
REQ-030 With the macro defined and count != 0, behaviour SHALL be identical to the non-bypass build.

Structure
REQ-031 Shared package handshake_pkg SHALL hold the clog2-based pointer-width function and the NUM_SLOTS legality constant range.
REQ-032 Storage SHALL be a sub-module handshake_fifo_storage (1 write port, 1 asynchronous read port, no reset); pointer, count and handshake logic SHALL remain in the top module.

Verification
REQ-033 Reset then idle -> outs_valid = 0 and ins_ready = 1 in cycle 1; with the bypass macro, ins_valid = 1 and ins = 0x1C -> outs = 0x1C the same cycle.
REQ-034 Push 0x1C, 0x2A, 0x3F, 0x44 with outs_ready = 0 and NUM_SLOTS = 4 -> ins_ready = 0 after the 4th push; then outs_ready = 1 -> outputs appear in that order, one per cycle.
REQ-035 Full with ins_valid = 1 and outs_ready = 1 -> pop occurs, no push that cycle, and ins_ready = 1 on the next cycle.
REQ-036 NUM_SLOTS = 3 with a continuous stream 0..9 and outs_ready held high -> pointers wrap 2 -> 0; outs = 0..9 in order with no bubbles after the first token.
REQ-037 Random ins_valid and outs_ready (50%), 1000 tokens -> scoreboard matches exactly, and outs holds stable while stalled.
REQ-038 rst asserted with count = 2 -> next cycle count = 0 and outs_valid = 0; the following push of 0x55 reads back 0x55.
